// File: rtl/obstacle_scheduler_if.sv
// Handshake-free signal bundle between the frame timing/game logic and the
// obstacle scheduler: raster position and game controls in, obstacle state out.
interface obstacle_scheduler_if;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        game_run;
    logic        collision;
    logic [9:0]  obstacle_x;
    logic        obstacle_active;
    logic [3:0]  speed;
    logic [15:0] score;
    logic        game_over;

    modport master (
        output hcount, vcount, game_run, collision,
        input  obstacle_x, obstacle_active, speed, score, game_over
    );

    modport slave (
        input  hcount, vcount, game_run, collision,
        output obstacle_x, obstacle_active, speed, score, game_over
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle spawner/scroller with score, speed ramp and collision halt.
// Optional macro OBSTACLE_SPEEDUP_EN enables the periodic speed ramp.
module obstacle_scheduler #(
    parameter int          SCREEN_WIDTH   = 640,
    parameter int          SCREEN_HEIGHT  = 480,
    parameter int          INIT_SPEED     = 2,
    parameter int          MAX_SPEED      = 8,
    parameter int          SPEEDUP_FRAMES = 600,
    parameter int          MIN_GAP_FRAMES = 30,
    parameter int          GAP_MASK       = 63,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  pix_clk,
    input  logic                  rst_n,
    obstacle_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SCROLL,
        HALT
    } state_t;

    localparam logic [9:0] PARK = 10'(SCREEN_WIDTH);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic        act_q, act_d;
    logic [15:0] score_q, score_d;
    logic        go_q, go_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  gap_load;
    logic [3:0]  spd;
    logic        tick;
    logic        ramp_en;
    logic        ramp_clr;

    assign tick = (bus.hcount == 10'd0) &&
                  (bus.vcount == 10'(SCREEN_HEIGHT));

    // Gap length sampled from the LFSR before it advances on this edge
    assign gap_load = 8'(MIN_GAP_FRAMES) +
                      (lfsr_q[7:0] & 8'(GAP_MASK));

    // Free-running Fibonacci LFSR, taps 16,14,13,11, one step per frame
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Next-state and datapath updates for the game FSM
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        act_d    = act_q;
        score_d  = score_q;
        go_d     = go_q;
        gap_d    = gap_q;
        ramp_en  = 1'b0;
        ramp_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_d   = PARK;
                act_d = 1'b0;
                if (bus.game_run) begin
                    state_d  = GAP;
                    score_d  = 16'd0;
                    go_d     = 1'b0;
                    gap_d    = gap_load;
                    ramp_clr = 1'b1;
                end
            end
            GAP: begin
                if (!bus.game_run) begin
                    state_d = IDLE;
                    x_d     = PARK;
                    act_d   = 1'b0;
                end else if (tick) begin
                    ramp_en = 1'b1;
                    if (gap_q == 8'd0) begin
                        state_d = SCROLL;
                        x_d     = PARK;
                        act_d   = 1'b1;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end
            SCROLL: begin
                if (!bus.game_run) begin
                    state_d = IDLE;
                    x_d     = PARK;
                    act_d   = 1'b0;
                end else if (bus.collision && act_q) begin
                    state_d = HALT;
                    go_d    = 1'b1;
                end else if (tick) begin
                    ramp_en = 1'b1;
                    if (x_q < {6'd0, spd}) begin
                        state_d = GAP;
                        x_d     = PARK;
                        act_d   = 1'b0;
                        gap_d   = gap_load;
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q - {6'd0, spd};
                    end
                end
            end
            HALT: begin
                if (!bus.game_run) begin
                    state_d = IDLE;
                    x_d     = PARK;
                    act_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Game state registers
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= PARK;
            act_q   <= 1'b0;
            score_q <= 16'd0;
            go_q    <= 1'b0;
            gap_q   <= 8'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            act_q   <= act_d;
            score_q <= score_d;
            go_q    <= go_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int FW = $clog2(SPEEDUP_FRAMES + 1);

    logic [FW-1:0] frame_q, frame_d;
    logic [3:0]    spd_q, spd_d;

    // Frame counter and saturating speed step every SPEEDUP_FRAMES ticks
    always_comb begin
        frame_d = frame_q;
        spd_d   = spd_q;
        if (ramp_clr) begin
            frame_d = '0;
            spd_d   = 4'(INIT_SPEED);
        end else if (ramp_en) begin
            if (frame_q == FW'(SPEEDUP_FRAMES - 1)) begin
                frame_d = '0;
                if (spd_q < 4'(MAX_SPEED)) begin
                    spd_d = spd_q + 4'd1;
                end
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    // Speed ramp registers
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            spd_q   <= 4'(INIT_SPEED);
        end else begin
            frame_q <= frame_d;
            spd_q   <= spd_d;
        end
    end

    assign spd = spd_q;
`else
    logic unused_ramp;

    assign unused_ramp = ramp_en ^ ramp_clr;
    assign spd         = 4'(INIT_SPEED);
`endif

    assign bus.obstacle_x      = x_q;
    assign bus.obstacle_active = act_q;
    assign bus.speed           = spd;
    assign bus.score           = score_q;
    assign bus.game_over       = go_q;

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Per-frame controller that drives the obstacle sprite renderer's obstacle_x input. It spawns an obstacle at the right screen edge and scrolls it left once per frame, during vertical blanking. When the obstacle leaves the screen it despawns and waits a pseudo-random gap before respawning. It also tracks score and speed, and freezes the scene when the top-level collision detector reports a hit.

Parameters:
SCREEN_WIDTH, 640, visible width; also the parked/off-screen x value
SCREEN_HEIGHT, 480, visible height; frame tick line
INIT_SPEED, 2, pixels per frame after start
MAX_SPEED, 8, speed saturation value
SPEEDUP_FRAMES, 600, frames between speed increments
MIN_GAP_FRAMES, 30, minimum frames between despawn and respawn
GAP_MASK, 63, mask applied to LFSR for extra random gap
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
pix_clk  in  1  pixel clock; hcount advances once per cycle
rst_n  in  1  asynchronous active-low reset
hcount  in  10  current pixel column
vcount  in  10  current line
game_run  in  1  level: 1 = play, 0 = return to idle
collision  in  1  level: obstacle and player opaque pixels overlap this cycle
obstacle_x  out  10  left edge for the obstacle renderer
obstacle_active  out  1  obstacle on screen
speed  out  4  current pixels per frame
score  out  16  obstacles cleared
game_over  out  1  collision latched

Behaviour:
- Clocking and reset: one clock, pix_clk. Reset rst_n is asynchronous and active-low. All state is registered.
- Reset values:
  - state = IDLE
  - obstacle_x = SCREEN_WIDTH
  - obstacle_active = 0
  - speed = INIT_SPEED
  - score = 0
  - game_over = 0
  - gap_cnt = 0, frame_cnt = 0, lfsr = LFSR_SEED
- frame_tick: combinational, asserted when hcount==0 && vcount==SCREEN_HEIGHT. This is exactly one pix_clk per frame, inside vertical blanking. Updates take effect on the edge where the tick is sampled; outputs are valid the next cycle. No change occurs during visible lines except collision handling.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances on every frame_tick in every state.
- Gap load value: MIN_GAP_FRAMES + (lfsr & GAP_MASK), computed from the pre-advance LFSR value, 8-bit result.
- IDLE:
  - obstacle_active = 0, obstacle_x = SCREEN_WIDTH.
  - game_run==1 → GAP. On this entry: score = 0, speed = INIT_SPEED, frame_cnt = 0, game_over = 0, gap_cnt loaded.
- GAP:
  - On frame_tick: if gap_cnt==0 → SCROLL with obstacle_x = SCREEN_WIDTH and obstacle_active = 1; else gap_cnt decrements.
- SCROLL, on frame_tick:
  - If obstacle_x < speed: despawn. obstacle_active = 0, obstacle_x = SCREEN_WIDTH, score increments (saturating at 16'hFFFF), gap_cnt loaded → GAP.
  - Otherwise obstacle_x = obstacle_x − speed. Exact arithmetic, so x reaches 0 when divisible; despawn happens on the following tick.
- Collision:
  - collision==1 in SCROLL with obstacle_active → HALT and game_over = 1, on any cycle.
  - obstacle_x and score freeze.
  - If collision and frame_tick coincide, collision wins and x is not updated.
  - collision is ignored in IDLE, GAP and HALT.
- HALT: all outputs hold. game_run==0 → IDLE; game_over and score are held until the next IDLE→GAP.
- game_run==0 in GAP or SCROLL → IDLE next cycle. The obstacle parks, score is retained.
- Speed ramp (GAP and SCROLL only):
  - frame_cnt counts frame_ticks.
  - At SPEEDUP_FRAMES−1 it wraps to 0 and speed increments, saturating at MAX_SPEED.
  - A new speed applies from the next tick.
- Reset mid-game returns to the reset values immediately, asynchronously.

Optional Feature:
Macro OBSTACLE_SPEEDUP_EN.
- Defined: speed ramps as described in Behaviour.
- Undefined: frame_cnt logic is removed, and speed stays at INIT_SPEED permanently.

Test Plan:
1. Reset release, game_run=0 for 3 frames → obstacle_x=640, obstacle_active=0, score=0, game_over=0, speed=2.
2. Set game_run=1 with LFSR_SEED=16'hACE1, so gap = 30 + (16'hACE1 & 63) = 30 + 33 = 63. Expect obstacle_active=1, x=640 after the 64th frame_tick; then x=638, 636 on successive ticks.
3. Scroll to x=0, then next tick (speed 2) → despawn, score=1, obstacle_active=0, x=640, state GAP.
4. Assert collision while x=400, mid-line, not on a tick → next cycle game_over=1, x stays 400 for 5 frames. Drop game_run → IDLE, x=640. Raise game_run → score=0, game_over=0.
5. Assert collision on the same cycle as frame_tick with x=300 → x remains 300, game_over=1.
6. With OBSTACLE_SPEEDUP_EN and SPEEDUP_FRAMES=4: speed 2→3 after 4 ticks, saturates at 8 after 24 ticks. Without the macro, speed stays 2.
